// File: rtl/mem_pkg.sv
// Shared data-memory definitions: depth, access-mode encodings, LSU states.
// Pure declarations; no latency or backpressure of its own.
package mem_pkg;

  localparam int RAM_SIZE_LOG_DEF = 8;

  localparam logic [2:0] BYTE        = 3'b000;
  localparam logic [2:0] HALF_WORD   = 3'b001;
  localparam logic [2:0] WORD        = 3'b010;
  localparam logic [2:0] U_BYTE      = 3'b100;
  localparam logic [2:0] U_HALF_WORD = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Mode/alignment legality only; the address range is checked by the user.
  function automatic logic mode_legal(input logic we, input logic [2:0] mode,
                                      input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (mode)
      BYTE:        ok = 1'b1;
      HALF_WORD:   ok = (off[0] == 1'b0);
      WORD:        ok = (off == 2'b00);
      U_BYTE:      ok = !we;
      U_HALF_WORD: ok = !we && (off[0] == 1'b0);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Core-side request/response bus of the load/store unit.
// Request is valid/ready; the response is held until resp_ready.
interface lsu_align_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_mode, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_mode, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align_lane_align.sv
// Byte-lane extraction (load) and merge (store) for one memory word.
// Purely combinational; no backpressure.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_mode,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [31:0] w_x;

  assign w_x = i_word >> {i_offset, 3'b000};

  always_comb begin
    o_load = 32'd0;
    case (i_mode)
      BYTE:        o_load = {{24{w_x[7]}}, w_x[7:0]};
      U_BYTE:      o_load = {24'd0, w_x[7:0]};
      HALF_WORD:   o_load = {{16{w_x[15]}}, w_x[15:0]};
      U_HALF_WORD: o_load = {16'd0, w_x[15:0]};
      WORD:        o_load = w_x;
      default:     o_load = 32'd0;
    endcase
  end

  always_comb begin
    o_merge = i_word;
    case (i_mode)
      BYTE:      o_merge[{i_offset, 3'b000} +: 8]        = i_wdata[7:0];
      HALF_WORD: o_merge[{i_offset[1], 4'b0000} +: 16]   = i_wdata[15:0];
      WORD:      o_merge = i_wdata;
      default:   o_merge = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Word-granular LSU: loads read+extract, stores read-modify-write as WORD writes.
// Latency load 2 / store 3 / error 1 cycle; req_ready only in IDLE, response held until accepted.
module lsu_align
  import mem_pkg::*;
#(
  parameter int RAM_SIZE_LOG = RAM_SIZE_LOG_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  lsu_align_if.slave  bus,
  output logic [31:0] o_mem_ra,
  output logic [2:0]  o_mem_rm,
  input  logic [31:0] i_mem_rd,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wa,
  output logic [2:0]  o_mem_wm,
  output logic [31:0] o_mem_wd
);

  localparam logic [32:0] ADDR_LIM = 33'd1 << (RAM_SIZE_LOG + 2);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic        r_we;
  logic [2:0]  r_mode;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_lane_word;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic [31:0] w_word_addr;

  assign w_accept    = bus.req_valid && (r_state == ST_IDLE);
  assign w_legal     = mode_legal(bus.req_we, bus.req_mode, bus.req_addr[1:0]) &&
                       ({1'b0, bus.req_addr} < ADDR_LIM);
  assign w_word_addr = {r_addr[31:2], 2'b00};
  // Loads extract from the live read data; stores merge into the captured word.
  assign w_lane_word = (r_state == ST_WRITE) ? r_word : i_mem_rd;

  lane_align u_lane (
    .i_word   (w_lane_word),
    .i_offset (r_addr[1:0]),
    .i_mode   (r_mode),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_mode  <= WORD;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_word  <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_mode  <= bus.req_mode;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_rdata <= 32'd0;
        r_err   <= !w_legal;
      end
      if (r_state == ST_READ) begin
        r_word <= i_mem_rd;
        if (!r_we) r_rdata <= w_load;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_legal ? ST_READ : ST_RESP;
      ST_READ:  w_next = r_we ? ST_WRITE : ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  if (bus.resp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  assign o_mem_rm = WORD;
  assign o_mem_wm = WORD;
  assign o_mem_ra = (r_state == ST_READ) ? w_word_addr : 32'd0;
  // Gated by reset so an aborted store drops its write enable immediately.
  assign o_mem_we = (r_state == ST_WRITE) && !i_reset;
  assign o_mem_wa = (r_state == ST_WRITE) ? w_word_addr : 32'd0;
  assign o_mem_wd = (r_state == ST_WRITE) ? w_merge : 32'd0;

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: behavioural byte-addressed memory model plus scenario tasks.
module tb_lsu_align;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] mem_ra;
  logic [2:0]  mem_rm;
  logic [31:0] mem_rd;
  logic        mem_we;
  logic [31:0] mem_wa;
  logic [2:0]  mem_wm;
  logic [31:0] mem_wd;

  lsu_align_if bus ();

  lsu_align #(.RAM_SIZE_LOG(8)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .bus      (bus),
    .o_mem_ra (mem_ra),
    .o_mem_rm (mem_rm),
    .i_mem_rd (mem_rd),
    .o_mem_we (mem_we),
    .o_mem_wa (mem_wa),
    .o_mem_wm (mem_wm),
    .o_mem_wd (mem_wd)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] dmem [256];
  logic [7:0]  ref_b [1024];
  int          we_cnt = 0;
  logic [31:0] last_wa, last_wd;
  logic [2:0]  last_wm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = dmem[mem_ra[9:2]];

  always @(negedge clk) begin
    if (mem_we) begin
      dmem[mem_wa[9:2]] = mem_wd;
      we_cnt++;
      last_wa = mem_wa;
      last_wd = mem_wd;
      last_wm = mem_wm;
    end
  end

  task automatic set_word(input int w, input logic [31:0] v);
    dmem[w] = v;
    for (int k = 0; k < 4; k++) ref_b[4*w+k] = v[8*k +: 8];
  endtask

  function automatic logic ref_legal(input logic we, input logic [2:0] mode, input int addr);
    logic ok;
    ok = (mode == 0 || mode == 1 || mode == 2 || mode == 4 || mode == 5);
    if (we && (mode == 4 || mode == 5)) ok = 0;
    if ((mode == 1 || mode == 5) && (addr % 2 != 0)) ok = 0;
    if (mode == 2 && (addr % 4 != 0)) ok = 0;
    if (addr >= 1024) ok = 0;
    return ok;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] mode, input int a);
    logic [7:0]  b;
    logic [15:0] h;
    b = ref_b[a];
    h = {ref_b[(a+1)%1024], ref_b[a]};
    case (mode)
      0: return {{24{b[7]}}, b};
      4: return {24'd0, b};
      1: return {{16{h[15]}}, h};
      5: return {16'd0, h};
      2: return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] mode, input int a, input logic [31:0] d);
    int n;
    n = (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_b[a+k] = d[8*k +: 8];
  endtask

  task automatic do_req(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_mode  = mode;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
    end
    if (!bus.resp_valid) begin
      total++; bad++;
      $display("FAIL resp_timeout: resp_valid=%0b after %0d cycles, required 1", bus.resp_valid, lat);
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %0b want 0", bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", bus.resp_err); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %0b want 1", bus.req_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
    total++; if (mem_ra !== 32'd0 || mem_wa !== 32'd0 || mem_wd !== 32'd0) begin
      bad++; $display("FAIL rst_mem_bus: ra=%h wa=%h wd=%h want all 0", mem_ra, mem_wa, mem_wd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_vectors;
    logic [31:0] addrs [3];
    logic [2:0]  modes [3];
    logic [31:0] exps  [3];
    logic [31:0] rd;
    logic        er;
    int          lat;
    addrs[0] = 32'h101; modes[0] = BYTE;        exps[0] = 32'h0000007F;
    addrs[1] = 32'h103; modes[1] = BYTE;        exps[1] = 32'hFFFFFF80;
    addrs[2] = 32'h102; modes[2] = U_HALF_WORD; exps[2] = 32'h000080FF;
    set_word(32'h40, 32'h80FF7F01);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, modes[i], addrs[i], 32'd0, rd, er, lat);
      total++; if (rd !== exps[i] || er !== 1'b0) begin
        bad++; $display("FAIL load_vec%0d: rdata=%h err=%0b want %h/0", i, rd, er, exps[i]);
      end
      total++; if (lat != 2) begin bad++; $display("FAIL load_lat%0d: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_store_byte;
    logic [31:0] rd;
    logic        er;
    int          lat, c0;
    set_word(32'h40, 32'h11223344);
    c0 = we_cnt;
    do_req(1'b1, BYTE, 32'h102, 32'h000000AB, rd, er, lat);
    ref_store(BYTE, 32'h102, 32'hAB);
    total++; if (we_cnt != c0 + 1) begin bad++; $display("FAIL sb_we_pulses: got %0d want 1", we_cnt - c0); end
    total++; if (last_wa !== 32'h100 || last_wd !== 32'h11AB3344 || last_wm !== WORD) begin
      bad++; $display("FAIL sb_write: wa=%h wd=%h wm=%0d want 100/11ab3344/2", last_wa, last_wd, last_wm);
    end
    total++; if (lat != 3 || er !== 1'b0 || rd !== 32'd0) begin
      bad++; $display("FAIL sb_resp: lat=%0d err=%0b rdata=%h want 3/0/0", lat, er, rd);
    end
    do_req(1'b0, WORD, 32'h100, 32'd0, rd, er, lat);
    total++; if (rd !== 32'h11AB3344 || er !== 1'b0) begin
      bad++; $display("FAIL sb_readback: got %h want 11ab3344", rd);
    end
  endtask

  task automatic test_store_half;
    logic [31:0] rd, expw;
    logic        er;
    int          lat;
    set_word(32'hFF, $urandom);
    expw = {16'hBEEF, ref_b[32'h3FD], ref_b[32'h3FC]};
    do_req(1'b1, HALF_WORD, 32'h3FE, 32'h1234BEEF, rd, er, lat);
    ref_store(HALF_WORD, 32'h3FE, 32'h1234BEEF);
    total++; if (last_wa !== 32'h3FC || last_wd !== expw) begin
      bad++; $display("FAIL sh_write: wa=%h wd=%h want 3fc/%h", last_wa, last_wd, expw);
    end
    total++; if (lat != 3 || er !== 1'b0) begin bad++; $display("FAIL sh_resp: lat=%0d err=%0b want 3/0", lat, er); end
  endtask

  task automatic test_errors;
    logic        wes   [5];
    logic [2:0]  modes [5];
    logic [31:0] addrs [5];
    logic [31:0] rd;
    logic        er;
    int          lat, c0;
    wes[0] = 0; modes[0] = HALF_WORD; addrs[0] = 32'h101;
    wes[1] = 0; modes[1] = WORD;      addrs[1] = 32'h102;
    wes[2] = 1; modes[2] = U_BYTE;    addrs[2] = 32'h100;
    wes[3] = 0; modes[3] = 3'b011;    addrs[3] = 32'h100;
    wes[4] = 0; modes[4] = WORD;      addrs[4] = 32'h400;
    c0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      do_req(wes[i], modes[i], addrs[i], 32'hDEADBEEF, rd, er, lat);
      total++; if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin
        bad++; $display("FAIL err_case%0d: err=%0b rdata=%h lat=%0d want 1/0/1", i, er, rd, lat);
      end
    end
    total++; if (we_cnt != c0) begin bad++; $display("FAIL err_no_write: pulses=%0d want 0", we_cnt - c0); end
  endtask

  task automatic test_stall;
    logic [31:0] expv;
    int          lat, c0;
    set_word(32'h80, $urandom);
    expv = ref_load(WORD, 32'h200);
    c0 = we_cnt;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_mode = WORD; bus.req_addr = 32'h200;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 10 && !bus.resp_valid) begin @(negedge clk); lat++; end
    total++; if (lat != 2) begin bad++; $display("FAIL stall_lat: got %0d want 2", lat); end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_mode = WORD;
    bus.req_addr = 32'h204; bus.req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== expv || bus.resp_err !== 1'b0 ||
                   bus.req_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: vld=%0b rdata=%h err=%0b rdy=%0b want 1/%h/0/0",
                        i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready, expv);
      end
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    total++; if (we_cnt != c0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL stall_ignored: pulses=%0d rdy=%0b want 0/1", we_cnt - c0, bus.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr, wd, rd, expv;
    logic        er, legal;
    int          lat, elat, nbad;
    nbad = 0;
    for (int i = 0; i < 60; i++) begin
      we   = $urandom_range(0, 1);
      mode = $urandom_range(0, 7);
      addr = $urandom_range(0, 32'h4FF);
      wd   = $urandom;
      legal = ref_legal(we, mode, addr);
      expv  = (legal && !we) ? ref_load(mode, addr) : 32'd0;
      elat  = !legal ? 1 : (we ? 3 : 2);
      do_req(we, mode, addr, wd, rd, er, lat);
      if (legal && we) ref_store(mode, addr, wd);
      total++; if (rd !== expv || er !== !legal || lat != elat) begin
        bad++; nbad++;
        if (nbad < 5) $display("FAIL rand%0d: we=%0b mode=%0d addr=%h rdata=%h err=%0b lat=%0d want %h/%0b/%0d",
                               i, we, mode, addr, rd, er, lat, expv, !legal, elat);
      end
    end
  endtask

  task automatic test_reset_in_write;
    logic [31:0] rd;
    logic        er;
    int          lat;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_mode = WORD;
    bus.req_addr = 32'h300; bus.req_wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rw_we_high: got %0b want 1", mem_we); end
    reset = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rw_we_drop: got %0b want 0", mem_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || mem_we !== 1'b0) begin
      bad++; $display("FAIL rw_idle: vld=%0b rdy=%0b we=%0b want 0/1/0", bus.resp_valid, bus.req_ready, mem_we);
    end
    @(posedge clk); #1;
    do_req(1'b0, WORD, 32'h300, 32'd0, rd, er, lat);
    total++; if (rd !== ref_load(WORD, 32'h300) || er !== 1'b0 || lat != 2) begin
      bad++; $display("FAIL rw_after: rdata=%h lat=%0d want %h/2", rd, lat, ref_load(WORD, 32'h300));
    end
  endtask

  task automatic test_mem_image;
    int diffs;
    diffs = 0;
    for (int w = 0; w < 256; w++)
      if (dmem[w] !== {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]}) diffs++;
    total++; if (diffs != 0) begin bad++; $display("FAIL mem_image: %0d words differ, want 0", diffs); end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_mode = WORD;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;
    for (int w = 0; w < 256; w++) set_word(w, $urandom);
    test_reset;
    test_load_vectors;
    test_store_byte;
    test_store_half;
    test_errors;
    test_mem_image;
    test_stall;
    test_random;
    test_reset_in_write;
    test_mem_image;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store unit sitting directly upstream of the data-memory port of mem: between the core's execute stage and mem's read port 2 (ra2/rm2/rd2) and write port (we/wa3/wm3/wd3).
- Converts byte and half-word accesses at any byte offset into word-granular accesses.
  - Loads: word read, then shift plus sign/zero extension.
  - Stores: read-modify-write, so mem only ever receives WORD-mode writes.
- Checks alignment and address range, with a valid/ready request handshake and a held response.

Parameters:
- RAM_SIZE_LOG, 8, log2 of data-memory depth in words; byte addresses >= 4*2**RAM_SIZE_LOG are out of range.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  BYTE/HALF_WORD/WORD/U_BYTE/U_HALF_WORD encoding (000/001/010/100/101).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response available; held until accepted.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal mode or out-of-range access.
- mem_ra  out  32  to mem ra2; word-aligned (low 2 bits 0).
- mem_rm  out  3  to mem rm2; constant WORD.
- mem_rd  in  32  from mem rd2; combinational read data.
- mem_we  out  1  to mem we.
- mem_wa  out  32  to mem wa3; word-aligned.
- mem_wm  out  3  to mem wm3; constant WORD.
- mem_wd  out  32  to mem wd3; merged word.

Behaviour:
- **Reset:** state = IDLE. resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_ra = 0, mem_wa = 0, mem_wd = 0. req_ready = 1 from the first cycle after reset.
- **States:** IDLE, READ, WRITE, RESP.
- **IDLE:** on req_valid & req_ready, latch we, mode, addr and wdata.
  - If the request is legal, go to READ.
  - Otherwise go to RESP with err = 1 and rdata = 0. No memory access is made.
- **Legality rules:**
  - mode must be in {000, 001, 010, 100, 101}.
  - Stores additionally reject 100 and 101.
  - Half-word modes require addr[0] = 0.
  - WORD requires addr[1:0] = 0.
  - addr must be < 4*2**RAM_SIZE_LOG.
- **READ (1 cycle):** drive mem_ra = {addr[31:2], 2'b00}; register mem_rd into word_q.
  - Load: compute the result from mem_rd, then go to RESP.
    - sh = addr[1:0]*8; x = mem_rd >> sh.
    - BYTE: sign-extend x[7:0]. U_BYTE: zero-extend x[7:0].
    - HALF_WORD: sign-extend x[15:0]. U_HALF_WORD: zero-extend x[15:0].
    - WORD: x.
  - Store: go to WRITE.
- **WRITE (exactly 1 cycle):** mem_we = 1, mem_wa = word address, mem_wd = merge.
  - BYTE: replace byte lane addr[1:0] of word_q with wdata[7:0].
  - HALF_WORD: replace half lane addr[1] with wdata[15:0].
  - WORD: wdata.
  - mem commits on the negedge inside this cycle. mem_we must be low in every other state.
  - Next state: RESP.
- **RESP:** resp_valid = 1 with stable rdata/err.
  - On resp_ready, go to IDLE.
  - resp_valid and resp_rdata/err must not change while stalled.
- **Latency from the accept edge:**
  - Load: resp_valid 2 cycles later.
  - Store: 3 cycles later.
  - Error: 1 cycle later.
- **Throughput:** IDLE is re-entered on the cycle after resp accept. No overlap of requests.
- **Reset mid-operation:** abort immediately to IDLE. A store reset while in WRITE: mem_we drops the same cycle reset is sampled; a write may already have been committed at the preceding negedge.
- req_* inputs are ignored outside IDLE.

Decomposition:
- **Package mem_pkg:** RAM_SIZE_LOG default, access-mode constants (BYTE…U_HALF_WORD), state enum lsu_state_t. Shared with mem's reader/writer.
- **Sub-module lane_align (combinational):** inputs word, offset[1:0], mode, wdata; outputs extracted load value and merged store word.
  - Instantiated once.
  - FSM, latches and handshake stay in lsu_align.

Test Plan:
- Memory word 0x40 = 0x80FF7F01 (byte 0x100 = word 0x40 offset 0). Expected load results:
  - load BYTE @0x101 -> rdata 0x0000007F.
  - load BYTE @0x103 -> 0xFFFFFF80.
  - load U_HALF_WORD @0x102 -> 0x000080FF.
  - All with resp_valid 2 cycles after accept, err 0.
- Store BYTE 0xAB @0x102 to word 0x11223344 -> a single mem_we pulse with mem_wa 0x100, mem_wd 0x11AB3344, mem_wm WORD. A subsequent WORD load @0x100 returns 0x11AB3344.
- Store HALF_WORD 0xBEEF @0x3FE (word 0xFF) -> mem_wd = {0xBEEF, old[15:0]}. resp after 3 cycles.
- Misaligned and illegal requests -> resp_err 1 one cycle after accept, mem_we never asserted, memory unchanged:
  - HALF_WORD @0x101.
  - WORD @0x102.
  - store U_BYTE.
  - mode 011.
  - addr 0x400 with RAM_SIZE_LOG 8.
- Hold resp_ready low 5 cycles -> resp_valid/rdata stable, req_ready 0. Asserting req_valid meanwhile is ignored (no mem access).
- Assert reset in WRITE -> next cycle state IDLE, mem_we 0, resp_valid 0, req_ready 1.
